// File: rtl/tow_pkg.sv
// rtl/tow_pkg.sv - shared types and constants for the tug-of-war core
package tow_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    ROUND_OVER = 2'd1,
    GAME_OVER  = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  localparam int SCORE_W = 4;

endpackage

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise one raw button and emit a single-cycle press pulse
module button_conditioner #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Rising edge of the synchronised level; a held button yields one pulse.
  assign pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/tug_of_war_core.sv
// rtl/tug_of_war_core.sv - tug-of-war position, round/match scoring and display state
module tug_of_war_core
  import tow_pkg::*;
#(
  parameter int NUM_LIGHTS   = 9,
  parameter int SCORE_MAX    = 7,
  parameter int PAUSE_CYCLES = 25000000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  left_raw,
  input  logic                  right_raw,
  input  logic                  new_game,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [SCORE_W-1:0]    score_left,
  output logic [SCORE_W-1:0]    score_right,
  output logic [1:0]            round_winner,
  output logic                  game_over
);

  localparam int PW = $clog2(NUM_LIGHTS);
  localparam int CW = $clog2(PAUSE_CYCLES + 1);

  localparam logic [PW-1:0]         POS_CENTRE    = PW'(NUM_LIGHTS / 2);
  localparam logic [PW-1:0]         POS_LEFTMOST  = PW'(NUM_LIGHTS - 1);
  localparam logic [CW-1:0]         CNT_LAST      = CW'(PAUSE_CYCLES - 1);
  localparam logic [SCORE_W-1:0]    SCORE_LAST    = SCORE_W'(SCORE_MAX - 1);
  localparam logic [NUM_LIGHTS-1:0] LIGHTS_CENTRE = NUM_LIGHTS'(1) << (NUM_LIGHTS / 2);
  // Each half includes the centre light.
  localparam logic [NUM_LIGHTS-1:0] LEFT_HALF     = ~(LIGHTS_CENTRE - NUM_LIGHTS'(1));
  localparam logic [NUM_LIGHTS-1:0] RIGHT_HALF    = (LIGHTS_CENTRE << 1) - NUM_LIGHTS'(1);

  function automatic logic [NUM_LIGHTS-1:0] f_onehot(input logic [PW-1:0] p);
    f_onehot = NUM_LIGHTS'(1) << p;
  endfunction

  logic w_left_pulse;
  logic w_right_pulse;
  logic w_left_only;
  logic w_right_only;
  logic [PW-1:0] w_pos_up;
  logic [PW-1:0] w_pos_down;

  state_t                r_state;
  logic [PW-1:0]         r_pos;
  logic [CW-1:0]         r_cnt;
  logic [NUM_LIGHTS-1:0] r_lights;
  logic [SCORE_W-1:0]    r_score_l;
  logic [SCORE_W-1:0]    r_score_r;
  logic [1:0]            r_winner;
  logic                  r_game_over;

  button_conditioner #(.SYNC_STAGES(SYNC_STAGES)) u_left_btn (
    .Clock (Clock),
    .Reset (Reset),
    .raw   (left_raw),
    .pulse (w_left_pulse)
  );

  button_conditioner #(.SYNC_STAGES(SYNC_STAGES)) u_right_btn (
    .Clock (Clock),
    .Reset (Reset),
    .raw   (right_raw),
    .pulse (w_right_pulse)
  );

  assign w_left_only  = w_left_pulse & ~w_right_pulse;
  assign w_right_only = w_right_pulse & ~w_left_pulse;
  assign w_pos_up     = r_pos + 1'b1;
  assign w_pos_down   = r_pos - 1'b1;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= PLAY;
      r_pos       <= POS_CENTRE;
      r_cnt       <= '0;
      r_lights    <= LIGHTS_CENTRE;
      r_score_l   <= '0;
      r_score_r   <= '0;
      r_winner    <= WIN_NONE;
      r_game_over <= 1'b0;
    end else if (new_game) begin
      r_state     <= PLAY;
      r_pos       <= POS_CENTRE;
      r_cnt       <= '0;
      r_lights    <= LIGHTS_CENTRE;
      r_score_l   <= '0;
      r_score_r   <= '0;
      r_winner    <= WIN_NONE;
      r_game_over <= 1'b0;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_left_only) begin
            if (r_pos == POS_LEFTMOST) begin
              r_score_l <= r_score_l + 1'b1;
              r_winner  <= WIN_LEFT;
              if (r_score_l == SCORE_LAST) begin
                r_state     <= GAME_OVER;
                r_lights    <= LEFT_HALF;
                r_game_over <= 1'b1;
              end else begin
                r_state  <= ROUND_OVER;
                r_cnt    <= '0;
                r_lights <= '0;
              end
            end else begin
              r_pos    <= w_pos_up;
              r_lights <= f_onehot(w_pos_up);
            end
          end else if (w_right_only) begin
            if (r_pos == '0) begin
              r_score_r <= r_score_r + 1'b1;
              r_winner  <= WIN_RIGHT;
              if (r_score_r == SCORE_LAST) begin
                r_state     <= GAME_OVER;
                r_lights    <= RIGHT_HALF;
                r_game_over <= 1'b1;
              end else begin
                r_state  <= ROUND_OVER;
                r_cnt    <= '0;
                r_lights <= '0;
              end
            end else begin
              r_pos    <= w_pos_down;
              r_lights <= f_onehot(w_pos_down);
            end
          end
        end
        ROUND_OVER: begin
          // Lights stay dark for PAUSE_CYCLES cycles, then the round restarts centred.
          if (r_cnt == CNT_LAST) begin
            r_state  <= PLAY;
            r_cnt    <= '0;
            r_pos    <= POS_CENTRE;
            r_lights <= LIGHTS_CENTRE;
            r_winner <= WIN_NONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        GAME_OVER: begin
        end
        default: begin
          r_state <= PLAY;
        end
      endcase
    end
  end

  assign lights       = r_lights;
  assign score_left   = r_score_l;
  assign score_right  = r_score_r;
  assign round_winner = r_winner;
  assign game_over    = r_game_over;

endmodule

// File: tb/tb_tug_of_war_core.sv
// tb/tb_tug_of_war_core.sv - self-checking bench for tug_of_war_core (9-light and 3-light builds)
module tb_tug_of_war_core;

  localparam int S_A = 2;
  localparam int P_A = 8;
  localparam int S_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_l, a_r, a_ng;
  logic [8:0] a_lights;
  logic [3:0] a_sl, a_sr;
  logic [1:0] a_win;
  logic       a_go;

  logic       b_rst, b_l, b_r, b_ng;
  logic [2:0] b_lights;
  logic [3:0] b_sl, b_sr;
  logic [1:0] b_win;
  logic       b_go;

  tug_of_war_core #(.NUM_LIGHTS(9), .SCORE_MAX(2), .PAUSE_CYCLES(P_A), .SYNC_STAGES(S_A)) u_dut_a (
    .Clock(clk), .Reset(a_rst), .left_raw(a_l), .right_raw(a_r), .new_game(a_ng),
    .lights(a_lights), .score_left(a_sl), .score_right(a_sr), .round_winner(a_win), .game_over(a_go)
  );

  tug_of_war_core #(.NUM_LIGHTS(3), .SCORE_MAX(7), .PAUSE_CYCLES(20), .SYNC_STAGES(S_B)) u_dut_b (
    .Clock(clk), .Reset(b_rst), .left_raw(b_l), .right_raw(b_r), .new_game(b_ng),
    .lights(b_lights), .score_left(b_sl), .score_right(b_sr), .round_winner(b_win), .game_over(b_go)
  );

  int checks   = 0;
  int failures = 0;

  string       q_name[$];
  logic [31:0] q_val[$];

  typedef struct {
    logic       l;
    logic       r;
    logic       ng;
    int         wait_cyc;
    logic [8:0] lights;
    logic [3:0] sl;
    logic [3:0] sr;
    logic [1:0] win;
    logic       go;
  } vec_t;

  vec_t vecs[24];

  function automatic logic [31:0] pk9(input logic [8:0] li, input logic [3:0] sl, input logic [3:0] sr,
                                      input logic [1:0] w, input logic g);
    return {12'd0, li, sl, sr, w, g};
  endfunction

  function automatic logic [31:0] pk3(input logic [2:0] li, input logic [3:0] sl, input logic [3:0] sr,
                                      input logic [1:0] w, input logic g);
    return {18'd0, li, sl, sr, w, g};
  endfunction

  function automatic logic [31:0] a_now();
    return pk9(a_lights, a_sl, a_sr, a_win, a_go);
  endfunction

  function automatic logic [31:0] b_now();
    return pk3(b_lights, b_sl, b_sr, b_win, b_go);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic sb_push(input string name, input logic [31:0] v);
    q_name.push_back(name);
    q_val.push_back(v);
  endtask

  task automatic sb_pop_cmp(input logic [31:0] act);
    string       n;
    logic [31:0] v;
    if (q_val.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=%h required=<entry>", act);
    end else begin
      n = q_name.pop_front();
      v = q_val.pop_front();
      chk(n, act, v);
    end
  endtask

  task automatic set_vec(input int i, input logic l, input logic r, input logic ng, input int w,
                         input logic [8:0] li, input logic [3:0] sl, input logic [3:0] sr,
                         input logic [1:0] win, input logic go);
    vecs[i].l = l; vecs[i].r = r; vecs[i].ng = ng; vecs[i].wait_cyc = w;
    vecs[i].lights = li; vecs[i].sl = sl; vecs[i].sr = sr; vecs[i].win = win; vecs[i].go = go;
  endtask

  task automatic run_vec(input int i);
    @(negedge clk);
    a_l = vecs[i].l; a_r = vecs[i].r; a_ng = vecs[i].ng;
    sb_push($sformatf("vec%0d", i), pk9(vecs[i].lights, vecs[i].sl, vecs[i].sr, vecs[i].win, vecs[i].go));
    @(negedge clk);
    a_ng = 1'b0;
    repeat (2) @(negedge clk);
    a_l = 1'b0; a_r = 1'b0;
    repeat (vecs[i].wait_cyc) @(negedge clk);
    sb_pop_cmp(a_now());
  endtask

  task automatic b_press(input logic l, input logic r, input int w);
    @(negedge clk);
    b_l = l; b_r = r;
    repeat (3) @(negedge clk);
    b_l = 1'b0; b_r = 1'b0;
    repeat (w) @(negedge clk);
  endtask

  int         dark;
  logic [1:0] win_at_dark;
  bit         seen;

  initial begin
    a_rst = 1'b1; a_l = 1'b0; a_r = 1'b0; a_ng = 1'b0;
    b_rst = 1'b1; b_l = 1'b0; b_r = 1'b0; b_ng = 1'b0;

    set_vec(0,  1, 0, 0, 4,  9'b001000000, 0, 0, 2'b00, 0);
    set_vec(1,  1, 0, 0, 4,  9'b010000000, 0, 0, 2'b00, 0);
    set_vec(2,  1, 1, 0, 4,  9'b010000000, 0, 0, 2'b00, 0);
    set_vec(3,  0, 1, 0, 4,  9'b001000000, 0, 0, 2'b00, 0);
    set_vec(4,  1, 0, 0, 4,  9'b010000000, 0, 0, 2'b00, 0);
    set_vec(5,  1, 0, 0, 4,  9'b100000000, 0, 0, 2'b00, 0);
    set_vec(6,  0, 1, 0, 4,  9'b000001000, 1, 0, 2'b00, 0);
    set_vec(7,  0, 1, 0, 4,  9'b000000100, 1, 0, 2'b00, 0);
    set_vec(8,  0, 1, 0, 4,  9'b000000010, 1, 0, 2'b00, 0);
    set_vec(9,  0, 1, 0, 4,  9'b000000001, 1, 0, 2'b00, 0);
    set_vec(10, 0, 1, 0, 12, 9'b000010000, 1, 1, 2'b00, 0);
    set_vec(11, 0, 1, 0, 4,  9'b000001000, 1, 1, 2'b00, 0);
    set_vec(12, 0, 1, 0, 4,  9'b000000100, 1, 1, 2'b00, 0);
    set_vec(13, 0, 1, 0, 4,  9'b000000010, 1, 1, 2'b00, 0);
    set_vec(14, 0, 1, 0, 4,  9'b000000001, 1, 1, 2'b00, 0);
    set_vec(15, 0, 1, 0, 4,  9'b000011111, 1, 2, 2'b10, 1);
    set_vec(16, 1, 0, 0, 4,  9'b000011111, 1, 2, 2'b10, 1);
    set_vec(17, 0, 1, 0, 12, 9'b000011111, 1, 2, 2'b10, 1);
    set_vec(18, 0, 0, 1, 4,  9'b000010000, 0, 0, 2'b00, 0);
    set_vec(19, 1, 0, 0, 4,  9'b000100000, 0, 0, 2'b00, 0);
    set_vec(20, 1, 0, 0, 4,  9'b000100000, 0, 0, 2'b00, 0);
    set_vec(21, 1, 0, 0, 4,  9'b001000000, 0, 0, 2'b00, 0);
    set_vec(22, 1, 0, 0, 4,  9'b010000000, 0, 0, 2'b00, 0);
    set_vec(23, 1, 0, 0, 4,  9'b100000000, 0, 0, 2'b00, 0);

    repeat (3) @(negedge clk);
    chk("a_reset_state", a_now(), pk9(9'b000010000, 0, 0, 2'b00, 0));
    chk("b_reset_state", b_now(), pk3(3'b010, 0, 0, 2'b00, 0));
    a_rst = 1'b0;
    b_rst = 1'b0;
    repeat (2) @(negedge clk);

    // Held button: exactly one move, landing SYNC_STAGES edges after the capturing edge.
    a_l = 1'b1;
    repeat (S_A) @(posedge clk);
    #1 chk("hold_before_move", {23'd0, a_lights}, {23'd0, 9'b000010000});
    @(posedge clk);
    #1 chk("hold_move", {23'd0, a_lights}, {23'd0, 9'b000100000});
    repeat (18) @(negedge clk);
    chk("hold_no_repeat", a_now(), pk9(9'b000100000, 0, 0, 2'b00, 0));
    a_l = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i <= 5; i++) run_vec(i);

    // Left round win from the leftmost light: count dark cycles.
    @(negedge clk);
    a_l = 1'b1;
    dark = 0; seen = 1'b0; win_at_dark = 2'b11;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 1) a_l = 1'b0;
      if (a_lights == 9'd0) begin
        if (!seen) win_at_dark = a_win;
        seen = 1'b1;
        dark++;
      end else if (seen) begin
        break;
      end
    end
    chk("pause_dark_cycles", 32'(dark), 32'(P_A));
    chk("pause_winner", {30'd0, win_at_dark}, {30'd0, 2'b01});
    chk("after_pause", a_now(), pk9(9'b000010000, 1, 0, 2'b00, 0));

    for (int i = 6; i <= 19; i++) run_vec(i);

    // new_game lands on the same edge as a left pulse and must win.
    @(negedge clk);
    a_l = 1'b1;
    sb_push("newgame_priority", pk9(9'b000010000, 0, 0, 2'b00, 0));
    repeat (S_A) @(negedge clk);
    a_ng = 1'b1;
    @(negedge clk);
    a_ng = 1'b0; a_l = 1'b0;
    repeat (4) @(negedge clk);
    sb_pop_cmp(a_now());

    for (int i = 20; i <= 23; i++) run_vec(i);

    // Asynchronous reset while the round-over counter is at 3.
    @(negedge clk);
    a_l = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (a_lights == 9'd0) seen = 1'b1;
    end
    a_l = 1'b0;
    chk("pre_reset_dark", a_now(), pk9(9'b000000000, 1, 0, 2'b01, 0));
    repeat (3) @(negedge clk);
    #2 a_rst = 1'b1;
    #1 chk("async_reset_mid_pause", a_now(), pk9(9'b000010000, 0, 0, 2'b00, 0));
    @(negedge clk);
    a_rst = 1'b0;

    // Three-light build: centre is index 1.
    b_press(1'b1, 1'b0, 4);
    chk("b_first_left", b_now(), pk3(3'b100, 0, 0, 2'b00, 0));
    b_press(1'b1, 1'b0, 4);
    chk("b_left_win", b_now(), pk3(3'b000, 1, 0, 2'b01, 0));
    repeat (25) @(negedge clk);
    chk("b_after_pause", b_now(), pk3(3'b010, 1, 0, 2'b00, 0));
    b_press(1'b0, 1'b1, 4);
    chk("b_right_move", b_now(), pk3(3'b001, 1, 0, 2'b00, 0));

    if (q_val.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", q_val.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
